ram_stream_reader: RTL and testbench

- Parametrised successor to the single-region RAM reader.
- Reads an arbitrary number of DW-bit cycles, starting at a runtime base address, through an AXI4 read master.
- Splits the read into bursts of up to BURST_CYCLES beats and keeps up to MAX_OUTSTANDING bursts in flight.
- Streams the data to an AXI-Stream output and marks the final beat with TLAST. Sits between the DDR/HBM interconnect and the packet-egress path.

---
 rtl/ram_stream_reader_pkg.sv | 25 ++
 rtl/ram_stream_reader_if.sv | 81 ++++++++
 rtl/ram_stream_reader_burst_planner.sv | 83 ++++++++
 rtl/ram_stream_reader.sv | 181 ++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: shared AXI geometry constants, FSM encoding and
// helpers for the streaming RAM reader. Optional error capture is enabled
// by defining RAM_STREAM_READER_ERR_EN.
package ram_stream_reader_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rsr_state_e;

    // log2 of the bytes in one data beat; doubles as the AXI ARSIZE code
    function automatic int beat_shift(input int dw);
        return $clog2(dw / 8);
    endfunction

    // bytes covered by one full-length burst
    function automatic longint burst_bytes(input int dw, input int burst_cycles);
        return longint'(burst_cycles) * longint'(dw / 8);
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: AXI4 master (AR/R used, AW/W/B idle) plus the
// AXI-Stream output of the reader. "master" is the reader's view,
// "slave" is the interconnect / downstream view.
interface ram_stream_reader_if #(
    parameter int DW = 512,
    parameter int AW = 64
);
    // read address channel
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [3:0]      arid;
    logic            arlock;
    logic [3:0]      arcache;
    logic [3:0]      arqos;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    // read data channel
    logic [DW-1:0]   rdata;
    logic            rvalid;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rready;
    // write channels, unused by a reader but present for the bus fabric
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [3:0]      awid;
    logic            awlock;
    logic [3:0]      awcache;
    logic [3:0]      awqos;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    // stream output
    logic [DW-1:0]   tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    modport master (
        output araddr, arlen, arsize, arburst, arid, arlock, arcache, arqos, arprot, arvalid,
        input  arready,
        input  rdata, rvalid, rresp, rlast,
        output rready,
        output awaddr, awlen, awsize, awburst, awid, awlock, awcache, awqos, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output tdata, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arid, arlock, arcache, arqos, arprot, arvalid,
        output arready,
        output rdata, rvalid, rresp, rlast,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awid, awlock, awcache, awqos, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  tdata, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/ram_stream_reader_burst_planner.sv
// ram_burst_planner: chops a transfer into AR bursts of up to BURST_CYCLES
// beats and limits the number of accepted-but-incomplete bursts to
// MAX_OUTSTANDING. ARVALID is registered and never drops while unaccepted.
module ram_burst_planner
    import ram_stream_reader_pkg::*;
#(
    parameter int DW              = 512,
    parameter int AW              = 64,
    parameter int BURST_CYCLES    = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] base_addr,
    input  logic [31:0]   total_cycles,
    output logic          ar_valid,
    output logic [AW-1:0] ar_addr,
    output logic [7:0]    ar_len,
    input  logic          ar_ready,
    input  logic          r_last_hs,
    output logic          ar_done
);
    localparam int OW         = $clog2(MAX_OUTSTANDING + 1);
    localparam int BEAT_SHIFT = beat_shift(DW);

    logic [31:0]   remaining_ar_q, remaining_ar_d;
    logic [AW-1:0] ar_addr_q, ar_addr_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic          ar_valid_q, ar_valid_d;
    logic [31:0]   burst;
    logic          ar_hs;
    logic          credit_ret;

    assign burst      = (remaining_ar_q > 32'(BURST_CYCLES)) ? 32'(BURST_CYCLES) : remaining_ar_q;
    assign ar_hs      = ar_valid_q && ar_ready;
    // spurious RLASTs with nothing in flight must not underflow the credit count
    assign credit_ret = r_last_hs && (outstanding_q != '0);

    assign ar_valid = ar_valid_q;
    assign ar_addr  = ar_addr_q;
    assign ar_len   = 8'(burst - 32'd1);
    assign ar_done  = ar_hs && (remaining_ar_q == burst);

    // next remaining count, address, credits and registered ARVALID
    always_comb begin
        remaining_ar_d = remaining_ar_q;
        ar_addr_d      = ar_addr_q;
        outstanding_d  = outstanding_q;
        if (load) begin
            remaining_ar_d = total_cycles;
            ar_addr_d      = base_addr;
        end else if (ar_hs) begin
            remaining_ar_d = remaining_ar_q - burst;
            ar_addr_d      = ar_addr_q + (AW'(burst) << BEAT_SHIFT);
        end
        if (ar_hs && !credit_ret) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!ar_hs && credit_ret) begin
            outstanding_d = outstanding_q - OW'(1);
        end
        if (ar_valid_q && !ar_ready) begin
            ar_valid_d = 1'b1;
        end else begin
            ar_valid_d = (remaining_ar_d != 32'd0) && (outstanding_d < OW'(MAX_OUTSTANDING));
        end
    end

    // planner state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_ar_q <= '0;
            ar_addr_q      <= '0;
            outstanding_q  <= '0;
            ar_valid_q     <= 1'b0;
        end else begin
            remaining_ar_q <= remaining_ar_d;
            ar_addr_q      <= ar_addr_d;
            outstanding_q  <= outstanding_d;
            ar_valid_q     <= ar_valid_d;
        end
    end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads total_cycles DW-bit beats from base_addr over
// AXI4 and streams them out with TLAST on the final beat. R data passes
// straight through to the stream with zero latency.
// Optional: define RAM_STREAM_READER_ERR_EN for sticky RRESP error capture.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DW              = 512,
    parameter int AW              = 64,
    parameter int BURST_CYCLES    = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CHANNEL         = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [31:0]          total_cycles,
    output logic                 idle,
    output logic                 done,
    ram_stream_reader_if.master  bus
`ifdef RAM_STREAM_READER_ERR_EN
    ,
    output logic                 rresp_err,
    output logic [31:0]          err_beat
`endif
);
    rsr_state_e  state_q, state_d;
    logic [31:0] beats_left_q, beats_left_d;
    logic        done_q, done_d;
    logic        active, beat_hs, last_hs;
    logic        plan_load, plan_ar_done;

    assign active  = (state_q != ST_IDLE);
    assign beat_hs = bus.rvalid && bus.tready;
    assign last_hs = active && beat_hs && (beats_left_q == 32'd1);

    // zero-latency data path; intermediate RLASTs stay internal
    assign bus.tdata  = bus.rdata;
    assign bus.tvalid = bus.rvalid;
    assign bus.rready = bus.tready;
    assign bus.tlast  = (beats_left_q == 32'd1);

    assign bus.arsize  = 3'(beat_shift(DW));
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arid    = '0;
    assign bus.arlock  = 1'b0;
    assign bus.arcache = '0;
    assign bus.arqos   = '0;
    assign bus.arprot  = '0;

    assign bus.awaddr  = '0;
    assign bus.awlen   = '0;
    assign bus.awsize  = '0;
    assign bus.awburst = '0;
    assign bus.awid    = '0;
    assign bus.awlock  = 1'b0;
    assign bus.awcache = '0;
    assign bus.awqos   = '0;
    assign bus.awprot  = '0;
    assign bus.awvalid = 1'b0;
    assign bus.wdata   = '0;
    assign bus.wstrb   = '0;
    assign bus.wlast   = 1'b0;
    assign bus.wvalid  = 1'b0;
    assign bus.bready  = 1'b0;

    assign idle = (state_q == ST_IDLE) && !start;
    assign done = done_q;

    ram_burst_planner #(
        .DW              (DW),
        .AW              (AW),
        .BURST_CYCLES    (BURST_CYCLES),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_planner (
        .clk          (clk),
        .reset        (reset),
        .load         (plan_load),
        .base_addr    (base_addr),
        .total_cycles (total_cycles),
        .ar_valid     (bus.arvalid),
        .ar_addr      (bus.araddr),
        .ar_len       (bus.arlen),
        .ar_ready     (bus.arready),
        .r_last_hs    (beat_hs && bus.rlast),
        .ar_done      (plan_ar_done)
    );

    // transfer FSM, beat counter and done pulse
    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        done_d       = 1'b0;
        plan_load    = 1'b0;
        if (active && beat_hs) begin
            beats_left_d = beats_left_q - 32'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (total_cycles == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = ST_ISSUE;
                        beats_left_d = total_cycles;
                        plan_load    = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (plan_ar_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: ;
            default: state_d = ST_IDLE;
        endcase
        if (last_hs) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end
    end

    // FSM and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            beats_left_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            done_q       <= done_d;
        end
    end

`ifdef RAM_STREAM_READER_ERR_EN
    logic        rresp_err_q, rresp_err_d;
    logic [31:0] err_beat_q, err_beat_d;
    logic [31:0] beat_idx_q, beat_idx_d;

    assign rresp_err = rresp_err_q;
    assign err_beat  = err_beat_q;

    // sticky error flag with the index of the first failing beat
    always_comb begin
        rresp_err_d = rresp_err_q;
        err_beat_d  = err_beat_q;
        beat_idx_d  = beat_idx_q;
        if ((state_q == ST_IDLE) && start) begin
            rresp_err_d = 1'b0;
            err_beat_d  = '0;
            beat_idx_d  = '0;
        end else if (active && beat_hs) begin
            beat_idx_d = beat_idx_q + 32'd1;
            if ((bus.rresp != RESP_OKAY) && !rresp_err_q) begin
                rresp_err_d = 1'b1;
                err_beat_d  = beat_idx_q;
            end
        end
    end

    // error capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rresp_err_q <= 1'b0;
            err_beat_q  <= '0;
            beat_idx_q  <= '0;
        end else begin
            rresp_err_q <= rresp_err_d;
            err_beat_q  <= err_beat_d;
            beat_idx_q  <= beat_idx_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bus.awready, bus.wready, bus.bresp, bus.bvalid, 32'(CHANNEL)};
`else
    logic unused_ok;
    assign unused_ok = ^{bus.awready, bus.wready, bus.bresp, bus.bvalid, bus.rresp, 32'(CHANNEL)};
`endif
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: randomized scoreboard bench. A behavioural AXI slave
// returns address-derived data; expected AR bursts and stream beats are
// computed from the transfer parameters and checked by a separate monitor.
module tb_ram_stream_reader;
    localparam int DW  = 512;
    localparam int AW  = 64;
    localparam int BC  = 64;
    localparam int MO  = 2;
    localparam int BPB = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [31:0]   total_cycles = '0;
    logic          idle, done;
`ifdef RAM_STREAM_READER_ERR_EN
    logic          rresp_err;
    logic [31:0]   err_beat;
`endif

    ram_stream_reader_if #(.DW(DW), .AW(AW)) bus ();

    ram_stream_reader #(
        .DW(DW), .AW(AW), .BURST_CYCLES(BC), .MAX_OUTSTANDING(MO), .CHANNEL(0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .total_cycles (total_cycles),
        .idle         (idle),
        .done         (done),
        .bus          (bus)
`ifdef RAM_STREAM_READER_ERR_EN
        ,
        .rresp_err    (rresp_err),
        .err_beat     (err_beat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; int len; } ar_t;
    typedef struct { logic [DW-1:0] data; logic last; } beat_t;

    int    checks = 0, fails = 0;
    int    ar_cnt = 0, beats_seen = 0, done_cnt = 0;
    ar_t   exp_ar[$];
    beat_t exp_beat[$];

    bit            r_en = 1'b1;
    bit            rnd_ready = 1'b0;
    logic [AW-1:0] err_addr = '1;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 64; k++)
            w[k*64 +: 64] = (a ^ 64'h5A5A_0000_0000_0000) + 64'(k) * 64'h0101_0101;
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // reference: every beat's data and where the bursts must land
    task automatic launch(input logic [AW-1:0] b, input int unsigned t);
        logic [AW-1:0]   a;
        longint unsigned rem;
        int              len;
        for (longint unsigned i = 0; i < t; i++)
            exp_beat.push_back('{data: mem_word(b + AW'(i * BPB)), last: (i == t - 1)});
        a   = b;
        rem = t;
        while (rem > 0) begin
            len = (rem > BC) ? BC : int'(rem);
            exp_ar.push_back('{addr: a, len: len - 1});
            a   = a + AW'(len * BPB);
            rem = rem - longint'(len);
        end
        beats_seen   = 0;
        start        = 1'b1;
        base_addr    = b;
        total_cycles = t;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_ar.delete();
        exp_beat.delete();
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int bound);
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while (done_cnt == c0 && n < bound) begin
            tick(1);
            n++;
        end
        checks++;
        if (done_cnt == c0) begin
            fails++;
            $display("FAIL %s: no done within %0d cycles", nm, bound);
            do_reset();
        end
        chk({nm, "_leftover"}, exp_beat.size() + exp_ar.size(), 0);
    endtask

    // AXI slave: in-order bursts, address-derived data, optional gaps
    initial begin
        bit            ar_hs_s, r_hs_s, rst_s, hold;
        logic [AW-1:0] a_s, ra;
        int            l_s;
        ar_t           pend[$];
        int            rb;
        rb = 0;
        bus.arready = 1'b1; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
        bus.rlast = 1'b0; bus.tready = 1'b1; bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bresp = 2'b00; bus.bvalid = 1'b0;
        forever begin
            @(negedge clk);
            rst_s   = reset;
            ar_hs_s = bus.arvalid && bus.arready;
            r_hs_s  = bus.rvalid && bus.rready;
            a_s     = bus.araddr;
            l_s     = int'(bus.arlen);
            @(posedge clk);
            #1;
            if (rst_s) begin
                pend.delete();
                rb = 0;
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
            end else begin
                if (ar_hs_s) pend.push_back('{addr: a_s, len: l_s});
                if (r_hs_s && pend.size() > 0) begin
                    if (rb == pend[0].len) begin
                        pend.delete(0);
                        rb = 0;
                    end else begin
                        rb++;
                    end
                end
            end
            hold = bus.rvalid && !r_hs_s && !rst_s;
            if (!hold) begin
                bus.rvalid = (pend.size() > 0) && r_en && (!rnd_ready || $urandom_range(3) != 0);
                if (pend.size() > 0) begin
                    ra = pend[0].addr + AW'(rb * BPB);
                    bus.rdata = mem_word(ra);
                    bus.rlast = (rb == pend[0].len);
                    bus.rresp = (ra == err_addr) ? 2'b10 : 2'b00;
                end
            end
            bus.arready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
            bus.tready  = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // scoreboard monitor
    initial begin
        bit            busy, exp_done, nxt_done, pv;
        int            outst;
        logic [AW-1:0] paddr;
        ar_t           ea;
        beat_t         eb;
        busy = 0; exp_done = 0; pv = 0; outst = 0; paddr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 0; exp_done = 0; pv = 0; outst = 0;
                continue;
            end
            nxt_done = 0;
            if (done || exp_done) begin
                checks++;
                if (done !== exp_done) begin
                    fails++;
                    $display("FAIL done_pulse: got %0b expected %0b", done, exp_done);
                end
            end
            if (exp_done && !start) begin
                checks++;
                if (idle !== 1'b1) begin
                    fails++;
                    $display("FAIL idle_at_done: got %0b expected 1", idle);
                end
            end
            if (done) done_cnt++;
            if (pv) begin
                checks++;
                if (bus.arvalid !== 1'b1 || bus.araddr !== paddr) begin
                    fails++;
                    $display("FAIL ar_hold: arvalid=%0b addr=%h expected arvalid=1 addr=%h",
                             bus.arvalid, bus.araddr, paddr);
                end
            end
            pv    = bus.arvalid && !bus.arready;
            paddr = bus.araddr;
            if (bus.arvalid && bus.arready) begin
                ar_cnt++;
                checks++;
                if (outst >= MO) begin
                    fails++;
                    $display("FAIL outstanding: got %0d in flight at new AR, limit %0d", outst, MO);
                end
                checks++;
                if (exp_ar.size() == 0) begin
                    fails++;
                    $display("FAIL ar_unexpected: addr=%h len=%0d expected none", bus.araddr, bus.arlen);
                end else begin
                    ea = exp_ar.pop_front();
                    if (bus.araddr !== ea.addr || int'(bus.arlen) != ea.len ||
                        int'(bus.arsize) != $clog2(BPB) || bus.arburst !== 2'b01) begin
                        fails++;
                        $display("FAIL ar: addr=%h len=%0d size=%0d burst=%0d expected addr=%h len=%0d size=%0d burst=1",
                                 bus.araddr, bus.arlen, bus.arsize, bus.arburst, ea.addr, ea.len, $clog2(BPB));
                    end
                end
                outst++;
            end
            if (bus.rvalid && bus.rready && bus.rlast && outst > 0) outst--;
            if (bus.tvalid && bus.tready && busy) begin
                beats_seen++;
                checks++;
                if (exp_beat.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: tlast=%0b expected no beat", bus.tlast);
                end else begin
                    eb = exp_beat.pop_front();
                    if (bus.tdata !== eb.data || bus.tlast !== eb.last) begin
                        fails++;
                        $display("FAIL beat[%0d]: tdata=%h tlast=%0b expected tdata=%h tlast=%0b",
                                 beats_seen - 1, bus.tdata, bus.tlast, eb.data, eb.last);
                    end
                    if (eb.last) begin
                        busy = 0;
                        nxt_done = 1;
                    end
                end
            end
            if (start && !busy) begin
                if (total_cycles == 32'd0) nxt_done = 1;
                else busy = 1;
            end
            exp_done = nxt_done;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // main stimulus
    initial begin
        int            c, d, n;
        logic [AW-1:0] b;
        int unsigned   t;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_idle", idle, 1);
        chk("reset_done", done, 0);
        chk("reset_arvalid", bus.arvalid, 0);
        chk("reset_tlast", bus.tlast, 0);
        tick(1);

        // three bursts: 64 + 64 + 22 beats on 4 KB steps
        launch(64'h1000, 150);
        wait_done("basic150", 1000);

        // zero-length request: done only, no AR
        c = ar_cnt;
        d = done_cnt;
        launch(64'h5000, 0);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_idle", idle, 1);
        chk("zero_arvalid", bus.arvalid, 0);
        tick(6);
        chk("zero_no_ar", ar_cnt - c, 0);
        chk("zero_one_done", done_cnt - d, 1);

        // credit limit with R withheld
        r_en = 1'b0;
        c = ar_cnt;
        launch(64'h10000, 640);
        tick(30);
        @(negedge clk);
        chk("credit_two_ar", ar_cnt - c, 2);
        chk("credit_arvalid_low", bus.arvalid, 0);
        tick(1);
        r_en = 1'b1;
        wait_done("credit640", 3000);
        chk("credit_total_ar", ar_cnt - c, 10);

        // random backpressure on every channel
        rnd_ready = 1'b1;
        launch(64'h100000, 1000);
        wait_done("rand1000", 8000);
        repeat (4) begin
            b = AW'($urandom_range(1023)) << 12;
            t = $urandom_range(300, 1);
            launch(b, t);
            wait_done("rand_xfer", 3000);
        end
        rnd_ready = 1'b0;

        // reset in the middle of a transfer, then a short clean one
        launch(64'h200000, 200);
        n = 0;
        while (beats_seen < 30 && n < 1000) begin
            tick(1);
            n++;
        end
        chk("reset_mid_reached", (beats_seen >= 30) ? 1 : 0, 1);
        reset = 1'b1;
        exp_ar.delete();
        exp_beat.delete();
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_arvalid", bus.arvalid, 0);
        chk("midreset_idle", idle, 1);
        tick(1);
        launch(64'h300000, 5);
        wait_done("post_reset5", 200);

`ifdef RAM_STREAM_READER_ERR_EN
        err_addr = 64'h400000 + 64'(7 * BPB);
        launch(64'h400000, 20);
        wait_done("err20", 500);
        chk("err_flag", rresp_err, 1);
        chk("err_beat", err_beat, 7);
        err_addr = '1;
        launch(64'h500000, 5);
        @(negedge clk);
        chk("err_cleared_on_start", rresp_err, 0);
        tick(1);
        wait_done("err_clean5", 200);
        chk("err_stays_clear", rresp_err, 0);
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
